matrix_rx_loader: RTL and testbench

//  Upstream stage of the UART matrix multiplier: consumes bytes from the UART receiver,

---
 rtl/matmul_pkg.sv | 18 +
 rtl/matrix_rx_loader.sv | 140 ++++++++++++++
 tb/tb_matrix_rx_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the UART matrix multiplier.
// State codes, operand geometry and default inter-byte timeout.
package matmul_pkg;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 3;
  localparam int ADDR_W = 4;

  // 20 ms of silence at 100 MHz, several byte times at slow baud rates
  localparam int TIMEOUT_CYCLES = 2000000;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_A    = 3'd1;
  localparam logic [2:0] LOAD_B    = 3'd2;
  localparam logic [2:0] START     = 3'd3;
  localparam logic [2:0] WAIT_MULT = 3'd4;

endpackage

// File: rtl/matrix_rx_loader.sv
// Frame loader: size header, then A and B row-major into operand buffers.
// Optional inter-byte timeout abort when TIMEOUT_EN is defined.
module matrix_rx_loader
  import matmul_pkg::*;
#(
  parameter int DATA_W         = matmul_pkg::DATA_W,
  parameter int MAX_N          = matmul_pkg::MAX_N,
  parameter int ADDR_W         = matmul_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = matmul_pkg::TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              mem_we_a,
  output logic              mem_we_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mat_n,
  output logic              mult_start,
  input  logic              mult_done,
  output logic              busy,
  output logic              size_err
);

  logic [2:0]        state;
  logic [1:0]        row;
  logic [1:0]        col;
  logic [1:0]        n_m1;
  logic              last_col;
  logic              last_row;
  logic              hdr_ok;
  logic              loading;
  logic              timeout;
  logic [ADDR_W-1:0] addr_nxt;

  assign n_m1     = mat_n - 2'd1;
  assign last_col = (col == n_m1);
  assign last_row = (row == n_m1);
  assign loading  = (state == LOAD_A) || (state == LOAD_B);
  assign busy     = (state != IDLE);
  assign hdr_ok   = (rx_data != '0) &&
                    (rx_data <= DATA_W'(MAX_N));
  assign addr_nxt = ADDR_W'(row) * ADDR_W'(MAX_N)
                  + ADDR_W'(col);

`ifdef TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout = loading && !rx_valid &&
                   (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (!loading || rx_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      mat_n      <= '0;
      size_err   <= 1'b0;
      mem_we_a   <= 1'b0;
      mem_we_b   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mult_start <= 1'b0;
    end else begin
      mem_we_a   <= 1'b0;
      mem_we_b   <= 1'b0;
      mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (hdr_ok) begin
              mat_n    <= rx_data[1:0];
              size_err <= 1'b0;
              row      <= '0;
              col      <= '0;
              state    <= LOAD_A;
            end else begin
              size_err <= 1'b1;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (timeout) begin
            size_err <= 1'b1;
            row      <= '0;
            col      <= '0;
            state    <= IDLE;
          end else if (rx_valid) begin
            mem_we_a  <= (state == LOAD_A);
            mem_we_b  <= (state == LOAD_B);
            mem_addr  <= addr_nxt;
            mem_wdata <= rx_data;
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= (state == LOAD_A) ? LOAD_B : START;
              end else begin
                row <= row + 2'd1;
              end
            end else begin
              col <= col + 2'd1;
            end
          end
        end
        START: begin
          mult_start <= 1'b1;
          state      <= WAIT_MULT;
        end
        WAIT_MULT: begin
          // a byte arriving with mult_done is dropped, not parsed
          if (mult_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_rx_loader.sv
// Bench for matrix_rx_loader: frame-level model plus directed frames.
// Define TIMEOUT_EN for both bench and RTL to exercise the timeout abort.
module tb_matrix_rx_loader;
  import matmul_pkg::*;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       mult_done = 1'b0;
  logic       mem_we_a;
  logic       mem_we_b;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [1:0] mat_n;
  logic       mult_start;
  logic       busy;
  logic       size_err;

  matrix_rx_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mat_n(mat_n), .mult_start(mult_start),
    .mult_done(mult_done), .busy(busy),
    .size_err(size_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int addr;
    int data;
    int due;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 1'b0;
  int m_mode = 0;
  int m_n = 0;
  int m_k = 0;
  int m_err = 0;
  int m_idle = 0;
  int m_start_due = -1;
  int m_starts = 0;
  int starts_seen = 0;
  int mem_a[16];
  int mem_b[16];

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // frame-level model: header, index into A/B, wait for done
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_mode = 0; m_n = 0; m_k = 0;
      m_err = 0; m_idle = 0;
      m_start_due = -1;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (rx_valid) begin
          if (rx_data >= 1 && rx_data <= MAX_N) begin
            m_n = int'(rx_data); m_k = 0;
            m_err = 0; m_idle = 0; m_mode = 1;
          end else begin
            m_err = 1;
          end
        end
        1: if (rx_valid) begin
          int nn, kk;
          wr_t e;
          nn = m_n * m_n;
          kk = m_k % nn;
          e.b = (m_k >= nn) ? 1 : 0;
          e.addr = (kk / m_n) * MAX_N + kk % m_n;
          e.data = int'(rx_data);
          e.due = cyc;
          exp_q.push_back(e);
          m_k++;
          m_idle = 0;
          if (m_k == 2 * nn) begin
            m_mode = 2;
            m_start_due = cyc + 1;
            m_starts++;
          end
        end else begin
`ifdef TIMEOUT_EN
          m_idle++;
          if (m_idle == TO) begin
            m_mode = 0;
            m_err = 1;
          end
`endif
        end
        default: if (mult_done) m_mode = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      if (!rst) begin
        chk("rst_outputs",
            int'({mem_we_a, mem_we_b, mult_start,
                  busy, size_err, mat_n,
                  mem_addr, mem_wdata}), 0);
      end else begin
        chk("we_exclusive", int'(mem_we_a & mem_we_b), 0);
        if (mem_we_a || mem_we_b) begin
          if (exp_q.size() == 0) begin
            chk("spurious_write", int'(mem_addr), -1);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_bank", int'(mem_we_b), e.b);
            chk("wr_addr", int'(mem_addr), e.addr);
            chk("wr_data", int'(mem_wdata), e.data);
            chk("wr_latency", cyc, e.due);
          end
          if (mem_we_a) mem_a[mem_addr] = int'(mem_wdata);
          if (mem_we_b) mem_b[mem_addr] = int'(mem_wdata);
        end else if (exp_q.size() > 0 &&
                     exp_q[0].due <= cyc) begin
          chk("missing_write", 0, 1);
          void'(exp_q.pop_front());
        end
        if (mult_start) starts_seen++;
        chk("mult_start", int'(mult_start),
            (cyc == m_start_due) ? 1 : 0);
        chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        chk("size_err", int'(size_err), m_err);
        chk("mat_n", int'(mat_n), m_n);
      end
    end
  end

  task automatic burst();
    @(posedge clk);
    #1;
    foreach (tx_q[i]) begin
      rx_data = tx_q[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    @(posedge clk);
    #1 mult_done = 1'b1;
    @(posedge clk);
    #1 mult_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #1 armed = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_mat_n", int'(mat_n), 0);

    // 1: full 3x3 frame
    tx_q = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03,
             8'h04, 8'h04, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h07, 8'h08, 8'h08, 8'h07,
             8'h08};
    burst();
    idle(4);
    chk("t1_starts", starts_seen, 1);
    chk("t1_busy_wait", int'(busy), 1);
    chk("t1_a4", mem_a[4], 3);
    chk("t1_a8", mem_a[8], 4);
    chk("t1_b8", mem_b[8], 8);
    done_pulse();
    idle(2);
    chk("t1_busy_done", int'(busy), 0);

    // 2: 2x2 frame, sparse addresses
    tx_q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08};
    burst();
    idle(4);
    chk("t2_mat_n", int'(mat_n), 2);
    chk("t2_a3", mem_a[3], 3);
    chk("t2_a2_stale", mem_a[2], 3);
    chk("t2_a5_stale", mem_a[5], 4);
    chk("t2_b4", mem_b[4], 8);
    chk("t2_starts", starts_seen, 2);
    done_pulse();

    // 3: bad headers, then a 1x1 frame
    tx_q = '{8'h00};
    burst();
    idle(2);
    chk("t3_err0", int'(size_err), 1);
    chk("t3_idle0", int'(busy), 0);
    tx_q = '{8'h04};
    burst();
    idle(2);
    chk("t3_err4", int'(size_err), 1);
    tx_q = '{8'h01, 8'h07, 8'h09};
    burst();
    idle(4);
    chk("t3_err_clr", int'(size_err), 0);
    chk("t3_a0", mem_a[0], 7);
    chk("t3_b0", mem_b[0], 9);
    chk("t3_starts", starts_seen, 3);
    done_pulse();

    // 4: bytes during WAIT_MULT are dropped
    tx_q = '{8'h01, 8'h11, 8'h22};
    burst();
    idle(3);
    tx_q = '{8'h55, 8'h66};
    burst();
    @(posedge clk);
    #1;
    rx_data = 8'h02;
    rx_valid = 1'b1;
    mult_done = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    mult_done = 1'b0;
    idle(2);
    chk("t4_coincident_idle", int'(busy), 0);
    chk("t4_a0_kept", mem_a[0], 8'h11);
    tx_q = '{8'h01, 8'h33, 8'h44};
    burst();
    idle(4);
    chk("t4_a0", mem_a[0], 8'h33);
    chk("t4_starts", starts_seen, 5);
    done_pulse();

    // 5: reset mid-load, then a fresh 3x3 frame
    tx_q = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    burst();
    idle(2);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_mat_n", int'(mat_n), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tx_q.push_back(8'h03);
    for (int i = 0; i < 18; i++) tx_q.push_back(8'(8'h10 + i));
    burst();
    idle(4);
    chk("t5_a8", mem_a[8], 8'h18);
    chk("t5_b0", mem_b[0], 8'h19);
    chk("t5_starts", starts_seen, 6);
    done_pulse();

    // 6: stall mid-frame
    tx_q = '{8'h02, 8'h01, 8'h02, 8'h03};
    burst();
    idle(150);
`ifdef TIMEOUT_EN
    chk("t6_timeout_idle", int'(busy), 0);
    chk("t6_timeout_err", int'(size_err), 1);
`else
    chk("t6_stall_busy", int'(busy), 1);
    chk("t6_stall_err", int'(size_err), 0);
`endif
    chk("t6_starts", starts_seen, 6);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    chk("end_pending", exp_q.size(), 0);
    chk("end_starts", starts_seen, m_starts);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
